hex_scan_driver: RTL and testbench
==================================

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Parameters
REQ-001 DIV, default 100000: clock cycles per digit slot; legal range 2..2^20.
REQ-002 BLANK, default 1000: leading cycles of each slot with all anodes off (anti-ghosting); legal range 0..DIV-1.

Interface
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 data_i  in  32  eight hex nibbles; digit k = data_i[4k+3:4k].
REQ-006 en_i  in  8  per-digit enable; bit k = 1 lights digit k.
REQ-007 load_i  in  1  single-cycle strobe; captures data_i and en_i.
REQ-008 hex  out  7  active-low segments; hex[0]=a … hex[6]=g.
REQ-009 AN  out  8  active-low anodes; AN[k] drives digit k.
REQ-010 frame_o  out  1  one-cycle pulse at the end of each full 8-digit scan.

Function
REQ-011 Prescaler cnt counts 0..DIV-1 and wraps; terminal count (TC) = cnt==DIV-1.
REQ-012 Digit index idx (3 bits) increments on TC and wraps 7→0.
REQ-013 On load_i=1, data_i and en_i are written to a pending register and the pending flag is set; a later load_i overwrites the pending contents, and the last value wins.
REQ-014 Pending contents transfer to the display register only on the frame boundary (TC with idx==7), and pending then clears; no tearing within a frame.
REQ-015 If load_i coincides with the frame boundary, the newly loaded data_i/en_i transfers directly to the display register and pending stays clear.
REQ-016 Load while idle (pending clear) and away from the boundary takes effect at the next frame boundary, never earlier.
REQ-017 hex and AN are registered and reflect idx/cnt with exactly 1 cycle latency.
REQ-018 AN = 8'hFF while cnt < BLANK or the display-register enable bit for idx is 0; otherwise AN = ~(8'h01 << idx).
REQ-019 hex = segment code of the display nibble idx whenever AN is not all ones; otherwise hex = 7'h7F.
REQ-020 Segment codes (hex, 7-bit): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-021 frame_o = 1 for exactly the cycle after the frame-boundary TC (registered), else 0.
REQ-022 At most one AN bit is low in any cycle.

Reset
REQ-023 While rst=1, and asynchronously on its assertion: cnt=0, idx=0, pending flag=0, pending and display registers = 0 (all digits disabled), AN=8'hFF, hex=7'h7F, frame_o=0.
REQ-024 Reset mid-scan or mid-pending discards the pending load; scanning restarts at digit 0, cnt 0, on the first edge after release.

Verification (DIV=4, BLANK=1)
REQ-025 Reset check: assert rst mid-slot → AN=FF, hex=7F, frame_o=0 immediately, without waiting for clk; after release, the first lit digit is 0.
REQ-026 Full-scan check: load data_i=32'h76543210, en_i=FF, then wait one frame → AN cycles FE,FD,…,7F and hex shows 40,79,24,30,19,12,02,78; each digit is lit 3 cycles after 1 blank cycle; frame_o pulses every 32 cycles.
REQ-027 Tear-free check: load 32'hFFFFFFFF mid-frame while showing 32'h0 → the remaining digits of the current frame still show 40; the next frame shows 0E on all digits.
REQ-028 Double-load check: load A then B within one frame → only B is ever displayed.
REQ-029 Boundary-load check: load_i asserted on the idx=7 TC cycle with data_i=32'h88888888 → the next frame shows 00 on all digits and pending is clear afterwards.
REQ-030 Enable-mask check: en_i=8'h05 → only AN=FE and FB are ever observed, and hex=7F in all other slots.

Source files
------------

// File: rtl/hex_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with a blanking window at the
// start of each digit slot and frame-synchronous, tear-free display updates.
module hex_scan_driver #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic [7:0]  en_i,
    input  logic        load_i,
    output logic [6:0]  hex,
    output logic [7:0]  AN,
    output logic        frame_o
);

    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_pend;
    logic [31:0]   r_pend_data;
    logic [7:0]    r_pend_en;
    logic [31:0]   r_disp_data;
    logic [7:0]    r_disp_en;
    logic [7:0]    r_an;
    logic [6:0]    r_hex;
    logic          r_frame;

    logic          w_tc;
    logic          w_frame;
    logic          w_blank;
    logic          w_digit_on;
    logic [3:0]    w_nib [8];
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg;
    logic [7:0]    w_an_next;

    assign w_tc    = (r_cnt == CNT_MAX);
    assign w_frame = w_tc && (r_idx == 3'd7);

    // A zero-length blanking window must never compare against zero.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_cnt < CW'(BLANK));
        end
    endgenerate

    assign w_digit_on = !w_blank && r_disp_en[r_idx];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign w_nib[gi]     = r_disp_data[4*gi +: 4];
            assign w_an_next[gi] = ~(w_digit_on && (r_idx == 3'(gi)));
        end
    endgenerate

    assign w_nibble = w_nib[r_idx];

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] code;
        code = 7'h7F;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            4'hF: code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    assign w_seg = seg7(w_nibble);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Display contents change only at the frame boundary; a load landing on
    // the boundary bypasses the pending stage and wins over older pending data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_data <= 32'h0;
            r_pend_en   <= 8'h00;
            r_disp_data <= 32'h0;
            r_disp_en   <= 8'h00;
        end else if (w_frame) begin
            r_pend <= 1'b0;
            if (load_i) begin
                r_disp_data <= data_i;
                r_disp_en   <= en_i;
            end else if (r_pend) begin
                r_disp_data <= r_pend_data;
                r_disp_en   <= r_pend_en;
            end
        end else if (load_i) begin
            r_pend      <= 1'b1;
            r_pend_data <= data_i;
            r_pend_en   <= en_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an    <= 8'hFF;
            r_hex   <= 7'h7F;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_next;
            r_hex   <= w_digit_on ? w_seg : 7'h7F;
            r_frame <= w_frame;
        end
    end

    assign AN      = r_an;
    assign hex     = r_hex;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver at DIV=4, BLANK=1 (32-cycle frames).
module tb_hex_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = 32'h0;
    logic [7:0]  en_i = 8'h00;
    logic        load_i = 1'b0;
    logic [6:0]  hex;
    logic [7:0]  AN;
    logic        frame_o;

    hex_scan_driver #(.DIV(4), .BLANK(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .en_i    (en_i),
        .load_i  (load_i),
        .hex     (hex),
        .AN      (AN),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          n = 0;
    int          lit_cnt = 0;
    logic [31:0] exp_data = 32'h0;
    logic [7:0]  exp_en = 8'h00;
    logic [31:0] nxt_data = 32'h0;
    logic [7:0]  nxt_en = 8'h00;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Sample after posedge n; outputs then reflect scan position n-1.
    task automatic tick();
        int         pos;
        int         idx;
        int         cnt;
        logic       lit;
        logic [7:0] e_an;
        logic [6:0] e_hex;
        @(negedge clk);
        n++;
        pos = (n - 1) % 32;
        if (pos == 0) begin
            exp_data = nxt_data;
            exp_en   = nxt_en;
            lit_cnt  = 0;
        end
        idx   = pos / 4;
        cnt   = pos % 4;
        lit   = (cnt >= 1) && exp_en[idx];
        e_an  = lit ? ~(8'h01 << idx) : 8'hFF;
        e_hex = lit ? seg_tbl[exp_data[idx*4 +: 4]] : 7'h7F;
        if (lit) lit_cnt++;
        check($sformatf("AN n=%0d", n), {24'h0, AN}, {24'h0, e_an});
        check($sformatf("hex n=%0d", n), {25'h0, hex}, {25'h0, e_hex});
        check($sformatf("frame n=%0d", n), {31'h0, frame_o}, {31'h0, (pos == 31)});
    endtask

    // Next load strobe will be captured at scan position p.
    task automatic goto_pos(input int p);
        while ((n % 32) != p) tick();
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] e);
        $display("[TB] load data=%h en=%h at pos %0d", d, e, n % 32);
        data_i = d;
        en_i   = e;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic run_to_frame_end();
        tick();
        while ((n % 32) != 0) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst AN", {24'h0, AN}, 32'hFF);
        check("rst hex", {25'h0, hex}, 32'h7F);
        check("rst frame", {31'h0, frame_o}, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        n        = 0;
        exp_data = 32'h0;
        exp_en   = 8'h00;
        nxt_data = 32'h0;
        nxt_en   = 8'h00;
        $display("[TB] reset released");
    endtask

    initial begin
        do_reset();

        // Full scan: frame 0 blank, frame 1 shows 0..7 on all digits.
        load(32'h76543210, 8'hFF);
        nxt_data = 32'h76543210; nxt_en = 8'hFF;
        run_to_frame_end();
        run_to_frame_end();
        check("full lit cycles", lit_cnt, 24);

        // Asynchronous reset mid-slot, with a load still pending.
        load(32'hAAAAAAAA, 8'hFF);
        goto_pos(14);
        #7;
        check("pre-rst AN", {24'h0, AN}, 32'hF7);
        check("pre-rst hex", {25'h0, hex}, 32'h30);
        rst = 1'b1;
        #1;
        check("async AN", {24'h0, AN}, 32'hFF);
        check("async hex", {25'h0, hex}, 32'h7F);
        check("async frame", {31'h0, frame_o}, 32'h0);
        do_reset();
        run_to_frame_end();
        run_to_frame_end();
        check("discard lit cycles", lit_cnt, 0);

        // Tear-free: showing zeros, load all-F mid-frame.
        load(32'h00000000, 8'hFF);
        nxt_data = 32'h0; nxt_en = 8'hFF;
        run_to_frame_end();
        goto_pos(10);
        load(32'hFFFFFFFF, 8'hFF);
        nxt_data = 32'hFFFFFFFF;
        run_to_frame_end();
        run_to_frame_end();

        // Double load within one frame: only the second is displayed.
        goto_pos(5);
        load(32'h13579BDF, 8'hFF);
        goto_pos(20);
        load(32'h02468ACE, 8'hFF);
        nxt_data = 32'h02468ACE;
        run_to_frame_end();
        run_to_frame_end();

        // Boundary load overrides older pending data and leaves pending clear.
        goto_pos(8);
        load(32'h11111111, 8'hFF);
        goto_pos(31);
        load(32'h88888888, 8'hFF);
        nxt_data = 32'h88888888;
        run_to_frame_end();
        run_to_frame_end();

        // Enable mask: only digits 0 and 2 ever lit.
        load(32'h76543210, 8'h05);
        nxt_data = 32'h76543210; nxt_en = 8'h05;
        run_to_frame_end();
        run_to_frame_end();
        check("mask lit cycles", lit_cnt, 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
